xor_gate_sync: RTL and testbench
================================

Name: xor_gate_sync

Overview:
- Registered, width-parameterised bitwise XOR stage with valid/ready handshake: y = a ^ b, plus reduction parity of the result.
- Used as a drop-in pipeline slice wherever an XOR result must be timed, e.g. checksum/parity paths.
- A two-entry skid buffer gives full throughput and registered in_ready, so the block can sit between any two handshake stages.
- With WIDTH=1 it is the registered form of a 2-input XOR gate.

Parameters:
- WIDTH, 1, bit width of operands a, b and result y (legal: 1..64).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  a/b operands valid this cycle
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  y/parity valid
- out_ready  input  1  downstream accepts y/parity this cycle
- y  output  WIDTH  registered bitwise a ^ b
- parity  output  1  registered XOR-reduction of y (1 = odd number of ones)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising clk edge.
- Reset values while rst is high at a clock edge:
  - out_valid=0, y=0, parity=0, skid entry empty.
  - in_ready=1 from the first cycle after rst deasserts.
  - In-flight data is discarded.
- Function: each accepted transfer produces y = a ^ b bitwise over WIDTH bits and parity = ^(a ^ b). No carries and no width growth.
- Input transfer occurs when in_valid && in_ready at a clock edge. Output transfer occurs when out_valid && out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid=1 when the output stage is empty or draining that same cycle.
- Throughput: one transfer per cycle with out_ready held high.
- Storage: output register (main) plus one skid register.
  - in_ready = !skid_full, registered (no combinational path from out_ready).
  - Main empty, or main draining (out_ready=1): accepted data loads main.
  - Main holding and stalled (out_ready=0) while in_ready=1: accepted data goes to the skid register, and in_ready drops next cycle.
  - When main drains and skid is full: skid moves to main, skid empties, and in_ready rises next cycle.
- Ordering: strictly FIFO. No result is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, y and parity hold their values.
- Boundary conditions:
  - Simultaneous input and output transfers in one cycle are legal and both occur.
  - in_valid while in_ready=0 is ignored; the source must hold its data.
  - rst asserted mid-stall clears both entries at that edge.
  - X on a or b while in_valid=0 must not propagate to state.
- y is updated only on load; it is not forced to 0 when invalid. Exception: after reset y=0.

Decomposition:
- Shared package xor_gate_pkg holds the default WIDTH constant and a function xor_reduce(WIDTH-bit) returning parity.
- Natural sub-module: skid_slice (generic WIDTH+1-bit two-entry valid/ready register slice).
- xor_gate_sync = combinational XOR/parity feeding skid_slice with data {parity, y}.

Test Plan:
- Truth table, WIDTH=1, out_ready=1: (a,b) = (0,0),(0,1),(1,0),(1,1), one per cycle -> y = 0,1,1,0 and parity = 0,1,1,0, each one cycle after its input transfer.
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_valid=0, y=0, parity=0. After release, in_ready=1 and the first operand pair appears 1 cycle after acceptance.
- Back-pressure, WIDTH=8: a=8'hF0, b=8'h0F then a=8'hAA, b=8'hAA with out_ready=0 -> y=8'hFF (parity 0) held stable; second item goes to skid and in_ready=0. Raise out_ready -> y=8'hFF, then 8'h00, in order.
- Full throughput, WIDTH=8: 16 random pairs back-to-back with out_ready=1 -> 16 results, each equal to a^b with correct parity, consecutive cycles, in order.
- Random stall: random in_valid/out_ready for 1000 cycles -> scoreboard matches a^b, no loss or duplication, and y stable whenever out_valid && !out_ready.
- Mid-stall reset: skid full, assert rst one cycle -> both entries cleared, out_valid=0, in_ready=1 afterwards.

Source files
------------

// File: rtl/xor_gate_pkg.sv
// Shared constants and helpers for the registered XOR/parity stage.
package xor_gate_pkg;

  localparam int unsigned DefaultWidth = 1;
  localparam int unsigned MaxWidth     = 64;

  // Operands narrower than MaxWidth are zero-extended, which leaves parity unchanged.
  function automatic logic xor_reduce(input logic [MaxWidth-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/skid_slice.sv
// Two-entry valid/ready register slice: main output register plus one skid register.
// ready_o is registered, so there is no combinational path from ready_i.
module skid_slice #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             main_valid_q, main_valid_d;
  logic [Width-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             in_fire;
  logic             main_free;

  assign in_fire   = valid_i && !skid_valid_q;
  assign main_free = !main_valid_q || ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_free) begin
      // A full skid implies ready_o was low, so no new input competes here.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) begin
          main_data_d = data_i;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign ready_o = !skid_valid_q;
  assign valid_o = main_valid_q;
  assign data_o  = main_data_q;

endmodule

// File: rtl/xor_gate_sync.sv
// Registered bitwise XOR with reduction parity behind a two-entry valid/ready slice.
module xor_gate_sync
  import xor_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             parity
);

  logic [WIDTH-1:0] y_comb;
  logic             parity_comb;
  logic [WIDTH:0]   out_data;

  assign y_comb      = a ^ b;
  assign parity_comb = xor_reduce(MaxWidth'(y_comb));

  skid_slice #(
    .Width(WIDTH + 1)
  ) u_slice (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(in_valid),
    .ready_o(in_ready),
    .data_i ({parity_comb, y_comb}),
    .valid_o(out_valid),
    .ready_i(out_ready),
    .data_o (out_data)
  );

  assign {parity, y} = out_data;

endmodule

// File: tb/tb_xor_gate_sync.sv
// Self-checking bench: WIDTH=1 truth table plus WIDTH=8 queue-model checks under random stalls.
module tb_xor_gate_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic v1, in_ready1, out_valid1, out_ready1, a1, b1, y1, p1;
  logic in_valid8, in_ready8, out_valid8, out_ready8, parity8;
  logic [7:0] a8, b8, y8;

  int n_total = 0;
  int n_bad   = 0;
  int n_acc   = 0;
  int n_out   = 0;
  logic [8:0] q8[$];

  xor_gate_sync #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .y(y1), .parity(p1)
  );

  xor_gate_sync #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .y(y8), .parity(parity8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {parity, y}: parity is odd population count of the XOR.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = a ^ b;
    return {1'($countones(r) % 2), r};
  endfunction

  // One cycle on dut8, called just after a falling edge.
  task automatic cyc8(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic ordy);
    logic in_fire, out_fire;
    in_valid8  = v;
    a8         = a;
    b8         = b;
    out_ready8 = ordy;
    check("out_valid", 64'(out_valid8), 64'(q8.size() > 0));
    check("in_ready", 64'(in_ready8), 64'(q8.size() < 2));
    if (out_valid8 && q8.size() > 0) begin
      check("y", 64'(y8), 64'(q8[0][7:0]));
      check("parity", 64'(parity8), 64'(q8[0][8]));
    end
    in_fire  = v && in_ready8;
    out_fire = out_valid8 && ordy;
    if (out_fire && q8.size() > 0) void'(q8.pop_front());
    if (in_fire) q8.push_back(model(a, b));
    n_acc += int'(in_fire);
    n_out += int'(out_fire);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_cycles(input int n);
    rst       = 1'b1;
    in_valid8 = 1'b1;
    v1        = 1'b1;
    repeat (n) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("rst out_valid", 64'(out_valid8), 64'd0);
      check("rst y", 64'(y8), 64'd0);
      check("rst parity", 64'(parity8), 64'd0);
    end
    rst       = 1'b0;
    in_valid8 = 1'b0;
    v1        = 1'b0;
    q8.delete();
    check("rst in_ready", 64'(in_ready8), 64'd1);
  endtask

  initial begin
    logic [3:0] tt;
    logic [1:0] ab;
    logic [7:0] ra, rb;
    logic pend, v, acc;

    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; out_ready1 = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;

    reset_cycles(2);

    // Truth table on the 1-bit instance; index i = {a,b}.
    tt = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      v1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("tt out_valid", 64'(out_valid1), 64'd1);
      check("tt y", 64'(y1), 64'(tt[i]));
      check("tt parity", 64'(p1), 64'(tt[i]));
      check("tt in_ready", 64'(in_ready1), 64'd1);
    end
    v1 = 1'b0;

    // Back-pressure: second item lands in the skid register.
    cyc8(1'b1, 8'hF0, 8'h0F, 1'b0);
    cyc8(1'b1, 8'hAA, 8'hAA, 1'b0);
    check("bp y held", 64'(y8), 64'hFF);
    check("bp parity", 64'(parity8), 64'd0);
    check("bp skid full", 64'(in_ready8), 64'd0);
    cyc8(1'b0, 8'h00, 8'h00, 1'b0);
    cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    check("bp second", 64'(y8), 64'h00);
    cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    check("bp empty", 64'(q8.size()), 64'd0);

    // Full throughput burst.
    n_acc = 0;
    n_out = 0;
    for (int i = 0; i < 16; i++) cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    check("thru accepted", 64'(n_acc), 64'd16);
    check("thru delivered", 64'(n_out), 64'd16);

    // Random stalls; source holds its operands until accepted.
    pend = 1'b0;
    ra = '0;
    rb = '0;
    for (int i = 0; i < 1000; i++) begin
      if (!pend) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
      end
      v   = pend || ($urandom % 4 != 0);
      acc = v && in_ready8;
      cyc8(v, ra, rb, 1'($urandom));
      pend = v && !acc;
    end
    repeat (4) cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    check("drain", 64'(q8.size()), 64'd0);

    // Reset while both entries are occupied.
    cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    cyc8(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    check("stall full", 64'(in_ready8), 64'd0);
    rst        = 1'b1;
    in_valid8  = 1'b0;
    out_ready8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q8.delete();
    check("mid rst out_valid", 64'(out_valid8), 64'd0);
    check("mid rst in_ready", 64'(in_ready8), 64'd1);
    check("mid rst y", 64'(y8), 64'd0);
    cyc8(1'b0, 8'h00, 8'h00, 1'b1);
    cyc8(1'b0, 8'h00, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
